// File: rtl/sr_event_debounce_pkg.sv
// Shared types and limits for the sr_event_debounce front end.
// Holds the debounce FSM state enum, glitch counter width and synchronizer depth limits.
package sr_debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_QUAL_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_QUAL_LOW  = 2'd3
  } sr_dbc_state_t;

  localparam int SR_DBC_GLITCH_W = 8;
  localparam int SR_DBC_SYNC_MIN = 2;
  localparam int SR_DBC_SYNC_MAX = 4;

  // Out-of-range depths are pulled back into the legal window rather than building a broken chain.
  function automatic int sr_dbc_clamp_sync(input int n);
    if (n < SR_DBC_SYNC_MIN) return SR_DBC_SYNC_MIN;
    if (n > SR_DBC_SYNC_MAX) return SR_DBC_SYNC_MAX;
    return n;
  endfunction

endpackage

// File: rtl/sr_event_debounce_sync_chain.sv
// Multi-flop synchronizer for one asynchronous input bit.
// Cleared asynchronously by clr; it never stalls, so hold has no effect on it.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic ds
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) chain <= '0;
    else     chain <= {chain[STAGES-2:0], din};
  end

  assign ds = chain[STAGES-1];

endmodule

// File: rtl/sr_event_debounce.sv
// Debounces a bouncy input and emits one-cycle set/reset pulses for a downstream S/R flag register.
// Optional macro SR_DEBOUNCE_GLITCH_CNT_EN adds a saturating count of aborted qualifications.
module sr_event_debounce
  import sr_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  input  logic hold,
  output logic s_out,
  output logic r_out,
  output logic en_out,
  output logic level,
  output logic busy
`ifdef SR_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [SR_DBC_GLITCH_W-1:0] glitch_cnt
`endif
);

  localparam int SYNC_N = sr_dbc_clamp_sync(SYNC_STAGES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit INSTANT = (DEBOUNCE_CYCLES == 1);

  logic          ds;
  sr_dbc_state_t state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic          level_next, s_next, r_next;

  sync_chain #(
    .STAGES(SYNC_N)
  ) u_sync (
    .clk(clk),
    .clr(clr),
    .din(din),
    .ds (ds)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= ST_LOW;
      cnt   <= '0;
      level <= 1'b0;
      s_out <= 1'b0;
      r_out <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      level <= level_next;
      s_out <= s_next;
      r_out <= r_next;
    end
  end

  // The counter tracks how many consecutive synchronized samples disagreed with the accepted level.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    level_next = level;
    s_next     = 1'b0;
    r_next     = 1'b0;
    if (!hold) begin
      case (state)
        ST_LOW: begin
          if (ds) begin
            if (INSTANT) begin
              state_next = ST_HIGH;
              level_next = 1'b1;
              s_next     = 1'b1;
              cnt_next   = '0;
            end else begin
              state_next = ST_QUAL_HIGH;
              cnt_next   = CNT_ONE;
            end
          end
        end
        ST_QUAL_HIGH: begin
          if (!ds) begin
            state_next = ST_LOW;
            cnt_next   = '0;
          end else if (cnt == CNT_LAST) begin
            state_next = ST_HIGH;
            level_next = 1'b1;
            s_next     = 1'b1;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (!ds) begin
            if (INSTANT) begin
              state_next = ST_LOW;
              level_next = 1'b0;
              r_next     = 1'b1;
              cnt_next   = '0;
            end else begin
              state_next = ST_QUAL_LOW;
              cnt_next   = CNT_ONE;
            end
          end
        end
        ST_QUAL_LOW: begin
          if (ds) begin
            state_next = ST_HIGH;
            cnt_next   = '0;
          end else if (cnt == CNT_LAST) begin
            state_next = ST_LOW;
            level_next = 1'b0;
            r_next     = 1'b1;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
        default: begin
          state_next = ST_LOW;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign busy   = (state == ST_QUAL_HIGH) || (state == ST_QUAL_LOW);
  assign en_out = s_out | r_out;

`ifdef SR_DEBOUNCE_GLITCH_CNT_EN
  logic aborting;

  // While qualifying, a sample matching the old level means the change was a bounce.
  assign aborting = !hold && busy && (ds == level);

  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      glitch_cnt <= '0;
    else if (aborting && (glitch_cnt != '1))
      glitch_cnt <= glitch_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_sr_event_debounce.sv
// Self-checking bench for sr_event_debounce (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Vector table, hand-written corner sequences, then random stimulus against a run-length model.
module tb_sr_event_debounce;

  localparam int SYNC = 2;
  localparam int DBC  = 4;

  logic clk = 1'b0;
  logic clr, din, hold;
  logic s_out, r_out, en_out, level, busy;
`ifdef SR_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_model = 1'b0;

  // Reference model: din history for the synchronizer delay, plus the accepted level and
  // the length of the current run of samples that disagree with it.
  logic m_sync [SYNC];
  logic m_level, m_s, m_r;
  int   m_run;
`ifdef SR_DEBOUNCE_GLITCH_CNT_EN
  int   m_glitch;
`endif

  typedef struct {
    logic din;
    logic hold;
    logic s;
    logic r;
    logic lvl;
    logic bsy;
  } vec_t;

  vec_t tbl [21];

  sr_event_debounce #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DBC)
  ) dut (
    .clk   (clk),
    .clr   (clr),
    .din   (din),
    .hold  (hold),
    .s_out (s_out),
    .r_out (r_out),
    .en_out(en_out),
    .level (level),
    .busy  (busy)
`ifdef SR_DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
    m_level = 1'b0;
    m_s     = 1'b0;
    m_r     = 1'b0;
    m_run   = 0;
`ifdef SR_DEBOUNCE_GLITCH_CNT_EN
    m_glitch = 0;
`endif
  endfunction

  function automatic void model_edge(input logic d, input logic h);
    logic ds;
    ds  = m_sync[SYNC-1];
    m_s = 1'b0;
    m_r = 1'b0;
    if (!h) begin
      if (ds != m_level) begin
        m_run++;
        if (m_run == DBC) begin
          m_s     = ds;
          m_r     = !ds;
          m_level = ds;
          m_run   = 0;
        end
      end else begin
`ifdef SR_DEBOUNCE_GLITCH_CNT_EN
        if (m_run > 0 && m_glitch < 255) m_glitch++;
`endif
        m_run = 0;
      end
    end
    for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = d;
  endfunction

  task automatic check_model();
    check_output("model.s_out", s_out, m_s);
    check_output("model.r_out", r_out, m_r);
    check_output("model.en_out", en_out, m_s | m_r);
    check_output("model.level", level, m_level);
    check_output("model.busy", busy, m_run > 0);
`ifdef SR_DEBOUNCE_GLITCH_CNT_EN
    check_output("model.glitch_cnt", glitch_cnt, 8'(m_glitch));
`endif
  endtask

  task automatic apply_stimulus(input logic d, input logic h);
    din  = d;
    hold = h;
    @(posedge clk);
    model_edge(d, h);
    #1;
    if (cmp_model) check_model();
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, ".s_out"}, s_out, 1'b0);
    check_output({tag, ".r_out"}, r_out, 1'b0);
    check_output({tag, ".en_out"}, en_out, 1'b0);
    check_output({tag, ".level"}, level, 1'b0);
    check_output({tag, ".busy"}, busy, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic d, h;

    // Rising qualification, falling qualification, then a 3-cycle bounce.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    clr  = 1'b0;
    din  = 1'b0;
    hold = 1'b0;
    model_reset();
    #2 clr = 1'b1;
    #1;
    check_all_zero("reset");
`ifdef SR_DEBOUNCE_GLITCH_CNT_EN
    check_output("reset.glitch_cnt", glitch_cnt, 8'd0);
`endif
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    repeat (3) apply_stimulus(1'b0, 1'b0);

    for (int i = 0; i < 21; i++) begin
      apply_stimulus(tbl[i].din, tbl[i].hold);
      check_output($sformatf("vec%0d.s_out", i), s_out, tbl[i].s);
      check_output($sformatf("vec%0d.r_out", i), r_out, tbl[i].r);
      check_output($sformatf("vec%0d.en_out", i), en_out, tbl[i].s | tbl[i].r);
      check_output($sformatf("vec%0d.level", i), level, tbl[i].lvl);
      check_output($sformatf("vec%0d.busy", i), busy, tbl[i].bsy);
    end
`ifdef SR_DEBOUNCE_GLITCH_CNT_EN
    check_output("bounce.glitch_cnt", glitch_cnt, 8'd1);
`endif

    cmp_model = 1'b1;

    // Hold for 10 cycles at cnt=2 of a rising qualification.
    repeat (4) apply_stimulus(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b1, 1'b1);
      check_output($sformatf("hold%0d.s_out", i), s_out, 1'b0);
      check_output($sformatf("hold%0d.busy", i), busy, 1'b1);
    end
    apply_stimulus(1'b1, 1'b0);
    check_output("hold_rel1.s_out", s_out, 1'b0);
    apply_stimulus(1'b1, 1'b0);
    check_output("hold_rel2.s_out", s_out, 1'b1);
    check_output("hold_rel2.level", level, 1'b1);
    repeat (8) apply_stimulus(1'b0, 1'b0);

    // Clear at cnt=3 with din held high; the rise must requalify from scratch.
    repeat (5) apply_stimulus(1'b1, 1'b0);
    check_output("pre_clr.busy", busy, 1'b1);
    clr = 1'b1;
    model_reset();
    #1;
    check_all_zero("clr_mid");
    #1 clr = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      apply_stimulus(1'b1, 1'b0);
      check_output($sformatf("post_clr%0d.s_out", k), s_out, k == 6);
      check_output($sformatf("post_clr%0d.level", k), level, k == 6);
    end
    repeat (8) apply_stimulus(1'b0, 1'b0);

    // 300 single-cycle glitches.
    for (int g = 0; g < 300; g++) begin
      apply_stimulus(1'b1, 1'b0);
      repeat (3) apply_stimulus(1'b0, 1'b0);
    end
    check_output("glitches.level", level, 1'b0);
`ifdef SR_DEBOUNCE_GLITCH_CNT_EN
    check_output("glitches.glitch_cnt", glitch_cnt, 8'd255);
`endif

    // Random bouncing input with occasional hold and clear.
    d = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) d = ~d;
      h = ($urandom_range(0, 7) == 0);
      apply_stimulus(d, h);
      if ($urandom_range(0, 299) == 0) begin
        clr = 1'b1;
        model_reset();
        #1;
        check_model();
        clr = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
